ap_ctrl_driver: RTL and testbench

AP_CTRL_DRIVER -- requirements
Module: ap_ctrl_driver

---
 rtl/ap_ctrl_pkg.sv | 7 +
 rtl/ap_ctrl_driver_sat_counter.sv | 15 +
 rtl/ap_ctrl_driver.sv | 93 +++++++++
 tb/tb_ap_ctrl_driver.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ap_ctrl_pkg.sv
// ap_ctrl_pkg: shared state encoding and default sizing for the ap_ctrl driver.
package ap_ctrl_pkg;
  localparam int CNT_W_DEF = 16;
  localparam int CYC_W_DEF = 32;
  localparam int TIMEOUT_DEF = 1024;
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE, S_ERR} state_t;
endpackage

// File: rtl/ap_ctrl_driver_sat_counter.sv
// sat_counter: clearable up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clock or posedge reset)
    if (reset) q <= '0;
    else if (clr) q <= '0;
    else if (en && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/ap_ctrl_driver.sv
// ap_ctrl_driver: issues cmd_count ap_start handshakes to a kernel, counts completions,
// and reports run time, first-transaction latency and a stall timeout.
module ap_ctrl_driver
  import ap_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int CYC_W = CYC_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             cmd_ready,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             ap_continue,
  output logic             busy,
  output logic             finish,
  output logic             error,
  output logic [CYC_W-1:0] total_cycles,
  output logic [CYC_W-1:0] first_latency,
  output logic [CNT_W-1:0] done_count
);
  state_t state, state_nx;
  logic [CNT_W-1:0] count_q, issued, issued_nx, done_nx;
  logic [CYC_W-1:0] idle_q;
  logic started, lat_stop;
  logic run, active, accept, take, hit, busy_kernel, quiet, timeout;
  assign run = state == S_RUN;
  assign active = run || state == S_DRAIN;
  assign accept = cmd_valid && state == S_IDLE;
  assign take = run && ap_ready;
  assign hit = active && ap_done && done_count != count_q;
  assign busy_kernel = take || (active && ap_done);
  assign quiet = active && !busy_kernel;
  assign timeout = quiet && idle_q >= CYC_W'(TIMEOUT - 1);
  assign issued_nx = issued + CNT_W'(take);
  assign done_nx = done_count + CNT_W'(hit);
  assign cmd_ready = state == S_IDLE;
  assign ap_start = run;
  assign ap_continue = active;
  assign busy = active;
  assign finish = state == S_DONE;
  assign error = state == S_ERR;
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = !accept ? S_IDLE : cmd_count == '0 ? S_DONE : S_RUN;
      S_RUN:   state_nx = (issued_nx == count_q && done_nx == count_q) ? S_DONE :
                          issued_nx == count_q ? S_DRAIN : timeout ? S_ERR : S_RUN;
      S_DRAIN: state_nx = done_nx == count_q ? S_DONE : timeout ? S_ERR : S_DRAIN;
      S_DONE:  state_nx = S_IDLE;
      S_ERR:   state_nx = S_ERR;
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      count_q <= '0;
      issued <= '0;
      done_count <= '0;
      started <= 1'b0;
      lat_stop <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        count_q <= cmd_count;
        issued <= '0;
        done_count <= '0;
        started <= 1'b0;
        lat_stop <= 1'b0;
      end else begin
        issued <= issued_nx;
        done_count <= done_nx;
        started <= started || take;
        lat_stop <= lat_stop || (active && ap_done && (started || take));
      end
    end
  // Latency runs from the cycle after the first accepted start through the first done.
  sat_counter #(.W(CYC_W)) u_total (
    .clock(clock), .reset(reset), .clr(accept), .en(active), .q(total_cycles)
  );
  sat_counter #(.W(CYC_W)) u_latency (
    .clock(clock), .reset(reset), .clr(accept), .en(active && started && !lat_stop),
    .q(first_latency)
  );
  sat_counter #(.W(CYC_W)) u_idle (
    .clock(clock), .reset(reset), .clr(accept || busy_kernel), .en(quiet), .q(idle_q)
  );
endmodule

// File: tb/tb_ap_ctrl_driver.sv
// tb_ap_ctrl_driver: directed checks of the ap_ctrl driver handshake, counters and timeout.
module tb_ap_ctrl_driver;
  logic clock, reset, cmd_valid, ap_ready, ap_done;
  logic [15:0] cmd_count;
  logic cmd_ready, ap_start, ap_continue, busy, finish, error;
  logic [31:0] total_cycles, first_latency;
  logic [15:0] done_count;
  int n_checks = 0;
  int n_fail = 0;

  ap_ctrl_driver #(.CNT_W(16), .CYC_W(32), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_count(cmd_count),
    .cmd_ready(cmd_ready), .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .ap_continue(ap_continue), .busy(busy), .finish(finish), .error(error),
    .total_cycles(total_cycles), .first_latency(first_latency), .done_count(done_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
    chk({tag, "_ap_start"}, 32'(ap_start), 0);
    chk({tag, "_ap_continue"}, 32'(ap_continue), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_finish"}, 32'(finish), 0);
    chk({tag, "_error"}, 32'(error), 0);
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_count = '0;
    ap_ready = 1'b0;
    ap_done = 1'b0;
    @(negedge clock);
    chk_idle_outputs("rst");
    chk("rst_total", total_cycles, 0);
    chk("rst_lat", first_latency, 0);
    chk("rst_done", 32'(done_count), 0);
    reset = 1'b0;
    tick();

    // Four transactions, ready every cycle, done three cycles after each ready.
    cmd_valid = 1'b1;
    cmd_count = 16'd4;
    tick();
    cmd_valid = 1'b0;
    chk("a_cmd_ready", 32'(cmd_ready), 0);
    for (int i = 1; i <= 7; i++) begin
      ap_ready = (i <= 4);
      ap_done = (i >= 4);
      chk($sformatf("a_start_%0d", i), 32'(ap_start), 32'(i <= 4));
      chk($sformatf("a_busy_%0d", i), 32'(busy), 1);
      chk($sformatf("a_finish_%0d", i), 32'(finish), 0);
      tick();
    end
    ap_ready = 1'b0;
    ap_done = 1'b0;
    chk("a_finish", 32'(finish), 1);
    chk("a_done_count", 32'(done_count), 4);
    chk("a_first_lat", first_latency, 3);
    chk("a_total", total_cycles, 7);
    chk("a_start_end", 32'(ap_start), 0);
    tick();
    chk_idle_outputs("a_after");
    chk("a_total_held", total_cycles, 7);

    // Two transactions, kernel stalls ready for five cycles.
    cmd_valid = 1'b1;
    cmd_count = 16'd2;
    tick();
    cmd_valid = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      ap_ready = (i == 6 || i == 7);
      ap_done = (i == 8 || i == 9);
      chk($sformatf("b_start_%0d", i), 32'(ap_start), 32'(i <= 7));
      chk($sformatf("b_done_cnt_%0d", i), 32'(done_count), 32'(i == 9));
      tick();
    end
    ap_ready = 1'b0;
    ap_done = 1'b0;
    chk("b_finish", 32'(finish), 1);
    chk("b_done_count", 32'(done_count), 2);
    chk("b_first_lat", first_latency, 2);
    chk("b_total", total_cycles, 9);
    tick();
    chk_idle_outputs("b_after");

    // Zero-length command completes immediately.
    cmd_valid = 1'b1;
    cmd_count = 16'd0;
    tick();
    cmd_valid = 1'b0;
    chk("c_finish", 32'(finish), 1);
    chk("c_total", total_cycles, 0);
    chk("c_start", 32'(ap_start), 0);
    chk("c_busy", 32'(busy), 0);
    chk("c_done_count", 32'(done_count), 0);
    tick();
    chk_idle_outputs("c_after");

    // Three transactions, done in the same cycle as ready.
    cmd_valid = 1'b1;
    cmd_count = 16'd3;
    tick();
    cmd_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      ap_ready = 1'b1;
      ap_done = 1'b1;
      chk($sformatf("d_start_%0d", i), 32'(ap_start), 1);
      chk($sformatf("d_finish_%0d", i), 32'(finish), 0);
      tick();
    end
    ap_ready = 1'b0;
    chk("d_finish", 32'(finish), 1);
    chk("d_done_count", 32'(done_count), 3);
    chk("d_first_lat", first_latency, 0);
    chk("d_total", total_cycles, 3);
    chk("d_start_end", 32'(ap_start), 0);
    tick();
    ap_done = 1'b0;
    chk("d_stray_done_ignored", 32'(done_count), 3);
    chk_idle_outputs("d_after");

    // Reset in the middle of a run.
    cmd_valid = 1'b1;
    cmd_count = 16'd5;
    tick();
    cmd_valid = 1'b0;
    ap_ready = 1'b1;
    tick();
    ap_done = 1'b1;
    tick();
    ap_ready = 1'b0;
    ap_done = 1'b0;
    chk("f_pre_start", 32'(ap_start), 1);
    chk("f_pre_done", 32'(done_count), 1);
    chk("f_pre_total", total_cycles, 2);
    #2 reset = 1'b1;
    #1;
    chk_idle_outputs("f_rst");
    chk("f_rst_total", total_cycles, 0);
    chk("f_rst_done", 32'(done_count), 0);
    @(negedge clock);
    reset = 1'b0;
    cmd_valid = 1'b1;
    cmd_count = 16'd1;
    tick();
    cmd_valid = 1'b0;
    ap_ready = 1'b1;
    ap_done = 1'b1;
    chk("f_run_start", 32'(ap_start), 1);
    tick();
    ap_ready = 1'b0;
    ap_done = 1'b0;
    chk("f_finish", 32'(finish), 1);
    chk("f_done_count", 32'(done_count), 1);
    chk("f_total", total_cycles, 1);
    chk("f_first_lat", first_latency, 0);
    tick();

    // Kernel never responds: timeout after 16 idle cycles, sticky until reset.
    cmd_valid = 1'b1;
    cmd_count = 16'd2;
    tick();
    cmd_valid = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("g_err_%0d", i), 32'(error), 0);
      chk($sformatf("g_start_%0d", i), 32'(ap_start), 1);
      tick();
    end
    chk("g_error", 32'(error), 1);
    chk("g_start", 32'(ap_start), 0);
    chk("g_continue", 32'(ap_continue), 0);
    chk("g_cmd_ready", 32'(cmd_ready), 0);
    cmd_valid = 1'b1;
    ap_ready = 1'b1;
    ap_done = 1'b1;
    repeat (4) tick();
    chk("g_sticky_error", 32'(error), 1);
    chk("g_sticky_cmd_ready", 32'(cmd_ready), 0);
    chk("g_sticky_start", 32'(ap_start), 0);
    cmd_valid = 1'b0;
    ap_ready = 1'b0;
    ap_done = 1'b0;
    reset = 1'b1;
    tick();
    chk_idle_outputs("g_rst");
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
